// File: rtl/stream_sort_engine.sv
// Frame sorter: loads up to N words over a valid/ready stream, sorts them
// in place with odd-even transposition (early exit on two swap-free passes),
// then drains them in order. Invalid slots sink to the end of the frame.
module stream_sort_engine #(
   parameter int N     = 8,
   parameter int WIDTH = 32,
   localparam int CW   = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_descend,
   input  logic             cfg_signed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [CW-1:0]    out_count,
   output logic             busy,
   output logic             sort_done
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] slot     [N];
   logic [WIDTH-1:0] slot_nxt [N];
   logic [N-1:0]     vld, vld_nxt;
   logic             any_swap;
   logic [IW-1:0]    wr_idx, rd_idx, pass;
   logic [CW-1:0]    count;
   logic             prev_swap;
   logic             descend, sgn;
   logic             in_fire, out_fire, last_beat, last_rd, sort_end;

   // key[a] > key[b] under the frame's signedness
   function automatic logic key_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
      if (s) return $signed(a) > $signed(b);
      else   return a > b;
   endfunction

   assign in_fire   = in_valid && in_ready && (state_q == LOAD);
   assign last_beat = in_last || (wr_idx == IW'(N - 1));
   assign out_fire  = out_valid && out_ready;
   assign last_rd   = (CW'(rd_idx) == count - CW'(1));
   assign sort_end  = (state_q == SORT) &&
                      ((pass == IW'(N - 1)) || ((pass != '0) && !prev_swap && !any_swap));

   // One compare-exchange pass; pair parity follows the pass number
   always_comb begin
      slot_nxt = slot;
      vld_nxt  = vld;
      any_swap = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         if ((i % 2) == int'(pass[0])) begin
            if ((!vld[i] && vld[i+1]) ||
                (vld[i] && vld[i+1] &&
                 (descend ? key_gt(slot[i+1], slot[i], sgn)
                          : key_gt(slot[i], slot[i+1], sgn)))) begin
               slot_nxt[i]   = slot[i+1];
               slot_nxt[i+1] = slot[i];
               vld_nxt[i]    = vld[i+1];
               vld_nxt[i+1]  = vld[i];
               any_swap      = 1'b1;
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (in_fire && last_beat) state_d = SORT;
         SORT:    if (sort_end)             state_d = DRAIN;
         DRAIN:   if (out_fire && last_rd)  state_d = LOAD;
         default:                           state_d = LOAD;
      endcase
   end

   // Output decode; data is forced to zero outside DRAIN
   always_comb begin
      out_valid = (state_q == DRAIN);
      busy      = (state_q != LOAD);
      out_data  = out_valid ? slot[rd_idx] : '0;
      out_last  = out_valid && last_rd;
      out_count = out_valid ? count : '0;
   end

   // State register and control counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD;
         in_ready  <= 1'b0;
         sort_done <= 1'b0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         pass      <= '0;
         prev_swap <= 1'b0;
         count     <= '0;
         vld       <= '0;
      end else begin
         state_q   <= state_d;
         in_ready  <= (state_d == LOAD);
         sort_done <= sort_end;
         case (state_q)
            LOAD: begin
               pass      <= '0;
               prev_swap <= 1'b0;
               if (in_fire) begin
                  vld[wr_idx] <= 1'b1;
                  wr_idx      <= last_beat ? '0 : wr_idx + IW'(1);
                  if (last_beat) count <= CW'(wr_idx) + CW'(1);
               end
            end
            SORT: begin
               vld       <= vld_nxt;
               prev_swap <= any_swap;
               if (!sort_end) pass <= pass + IW'(1);
            end
            DRAIN: begin
               if (out_fire) begin
                  rd_idx <= last_rd ? '0 : rd_idx + IW'(1);
                  if (last_rd) vld <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Slot storage and per-frame compare mode
   always_ff @(posedge clk) begin
      if (in_fire) begin
         slot[wr_idx] <= in_data;
         if (wr_idx == '0) begin
            descend <= cfg_descend;
            sgn     <= cfg_signed;
         end
      end else if (state_q == SORT) begin
         slot <= slot_nxt;
      end
   end

endmodule

// File: tb/tb_stream_sort_engine.sv
// Bench for stream_sort_engine (N=8, WIDTH=8): directed frames plus random
// frames compared against a stable insertion-sort reference.
module tb_stream_sort_engine;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_descend, cfg_signed;
   logic          in_valid, in_ready, in_last;
   logic [W-1:0]  in_data;
   logic          out_valid, out_ready, out_last;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;
   logic          busy, sort_done;

   int ntests = 0;
   int nfail  = 0;

   logic [W-1:0] frame_q[$];
   logic [W-1:0] exp_q[$];

   stream_sort_engine #(.N(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .cfg_descend(cfg_descend), .cfg_signed(cfg_signed),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_count(out_count), .busy(busy), .sort_done(sort_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int keyv(input logic [W-1:0] w, input bit sg);
      return sg ? int'($signed(w)) : int'(w);
   endfunction

   // Stable reference sort of frame_q into exp_q
   task automatic build_expected(input bit desc, input bit sg);
      int pos;
      exp_q.delete();
      foreach (frame_q[i]) begin
         pos = exp_q.size();
         for (int j = 0; j < exp_q.size(); j++) begin
            if (desc ? (keyv(frame_q[i], sg) > keyv(exp_q[j], sg))
                     : (keyv(frame_q[i], sg) < keyv(exp_q[j], sg))) begin
               pos = j;
               break;
            end
         end
         exp_q.insert(pos, frame_q[i]);
      end
   endtask

   // cfg is flipped on later beats: only beat 0 may set the frame mode
   task automatic send_frame(input bit use_last, input bit desc, input bit sg);
      int guard;
      for (int i = 0; i < frame_q.size(); i++) begin
         in_valid    = 1'b1;
         in_data     = frame_q[i];
         in_last     = use_last && (i == frame_q.size() - 1);
         cfg_descend = (i == 0) ? desc : ~desc;
         cfg_signed  = (i == 0) ? sg : ~sg;
         guard = 0;
         while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
         check("in_ready_wait", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      build_expected(desc, sg);
   endtask

   task automatic recv(input int mode);
      int k, n, guard;
      logic stalled;
      logic [W-1:0] held;
      k = 0; n = exp_q.size(); guard = 0; stalled = 1'b0; held = '0;
      while (k < n && guard < 400) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (guard % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (stalled) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held);
         end
         if (out_valid) begin
            check("data", out_data, exp_q[k]);
            check("last", out_last, (k == n - 1));
            check("count", out_count, n);
            stalled = !out_ready;
            held    = out_data;
            if (out_ready) k++;
         end else begin
            stalled = 1'b0;
         end
         @(posedge clk); #1;
         guard++;
      end
      check("drain_beats", k, n);
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
   endtask

   // exp_passes < 0 skips the latency check
   task automatic run_frame(input bit use_last, input bit desc, input bit sg,
                            input int mode, input int exp_passes);
      int lat;
      out_ready = 1'b0;
      send_frame(use_last, desc, sg);
      check("sort_in_ready", in_ready, 0);
      check("sort_busy", busy, 1);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("out_valid_rise", out_valid, 1);
      if (exp_passes >= 0) check("latency_passes", lat, exp_passes);
      check("sort_done_pulse", sort_done, 1);
      recv(mode);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_out_count"}, out_count, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_sort_done"}, sort_done, 0);
      check({tag, "_in_ready"}, in_ready, 0);
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      check("rel_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      check("rel_in_ready_high", in_ready, 1);
   endtask

   initial begin
      int len;
      bit ul, d, s;
      rst = 1'b1; cfg_descend = 0; cfg_signed = 0;
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
      #12;
      check_all_zero("reset");
      release_reset();

      // 1: ascending unsigned full frame
      frame_q = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
      run_frame(1, 0, 0, 0, -1);

      // 2: descending signed
      frame_q = '{8'hFF, 8'd5, 8'hFD, 8'd0, 8'd2, 8'd7, 8'hF8, 8'd4};
      run_frame(1, 1, 1, 0, -1);

      // 3: partial frame
      frame_q = '{8'd9, 8'd1, 8'd4};
      run_frame(1, 0, 0, 0, -1);

      // 4: sorted needs 2 passes, reversed needs 8; frame ends at N without in_last
      frame_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      run_frame(0, 0, 0, 0, 2);
      frame_q = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      run_frame(1, 0, 0, 0, 8);

      // single-word frame still takes two passes
      frame_q = '{8'd42};
      run_frame(1, 0, 0, 1, 2);

      // 5: equal keys with toggling backpressure
      frame_q = '{8'h10, 8'h10, 8'h05};
      run_frame(1, 0, 0, 1, -1);

      // 6: reset mid-SORT
      frame_q = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      send_frame(1, 0, 0);
      @(posedge clk); #1;
      check("midsort_busy", busy, 1);
      rst = 1'b1; #1;
      check_all_zero("rst_sort");
      release_reset();

      // reset mid-DRAIN
      frame_q = '{8'd30, 8'd20, 8'd10};
      send_frame(1, 0, 0);
      for (int i = 0; i < 20 && !out_valid; i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("middrain_valid", out_valid, 1);
      rst = 1'b1; #1;
      check_all_zero("rst_drain");
      release_reset();

      frame_q = '{8'd2, 8'd1};
      run_frame(1, 0, 0, 0, -1);

      // random frames with duplicates, mixed modes and backpressure
      for (int f = 0; f < 24; f++) begin
         len = $urandom_range(1, N);
         frame_q.delete();
         for (int i = 0; i < len; i++)
            frame_q.push_back(f[0] ? W'($urandom_range(0, 15)) : W'($urandom));
         ul = (len < N) ? 1'b1 : 1'($urandom_range(0, 1));
         d  = 1'($urandom_range(0, 1));
         s  = 1'($urandom_range(0, 1));
         run_frame(ul, d, s, $urandom_range(0, 2), -1);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
